uart_fifo: RTL and testbench



---
 rtl/uart_fifo.sv | 272 +++++++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// Memory-mapped UART with TX/RX FIFOs, runtime parity/stop-bit control,
// sticky receive error flags and a level interrupt.
module uart_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int BAUD_RST   = 434
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        uart_rx_i,
    output logic        uart_tx_o,
    input  logic        wr_en_i,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_data_i,
    input  logic        rd_en_i,
    input  logic [31:0] rd_addr_i,
    output logic [31:0] rd_data_o,
    output logic        irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [6:0]  ctrl_q;
    logic [15:0] baud_q;
    logic        ovr_q, ferr_q, perr_q, irq_q;
    logic [31:0] rd_data_q, rd_mux_s;
    logic [7:0]  status_s;

    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic        tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic        tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
    logic [7:0]  tx_head_s, rx_head_s;

    logic wr_ctrl_s, wr_stat_s, wr_baud_s, wr_tx_s, rd_rx_s;
    logic unused_s;

    state_t      tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, tx_baud_q, tx_baud_d;
    logic [2:0]  tx_bit_q, tx_bit_d, tx_cfg_q, tx_cfg_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        tx_par_q, tx_par_d, tx_stop_q, tx_stop_d, tx_line_q, tx_line_d;
    logic        tx_tick_s, tx_done_s, tx_busy_s;

    state_t      rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, rx_baud_q, rx_baud_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [1:0]  rx_cfg_q, rx_cfg_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        rx_pbad_q, rx_pbad_d, rx_s1_q, rx_s2_q, rx_s3_q;
    logic        rx_tick_s, rx_good_s, set_ferr_s, set_perr_s, set_ovr_s;

    assign unused_s  = ^{wr_addr_i[31:8], rd_addr_i[31:8], wr_data_i[31:16]};
    assign wr_ctrl_s = wr_en_i && (wr_addr_i[7:0] == 8'h00);
    assign wr_stat_s = wr_en_i && (wr_addr_i[7:0] == 8'h04);
    assign wr_baud_s = wr_en_i && (wr_addr_i[7:0] == 8'h08);
    assign wr_tx_s   = wr_en_i && (wr_addr_i[7:0] == 8'h0C);
    assign rd_rx_s   = rd_en_i && (rd_addr_i[7:0] == 8'h10);

    assign tx_empty_s = (tx_wp_q == tx_rp_q);
    assign tx_full_s  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
    assign rx_empty_s = (rx_wp_q == rx_rp_q);
    assign rx_full_s  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
    assign tx_head_s  = tx_mem[tx_rp_q[AW-1:0]];
    assign rx_head_s  = rx_mem[rx_rp_q[AW-1:0]];

    // A push on a full FIFO is still accepted when a pop frees a slot the same cycle.
    assign tx_push_s = wr_tx_s && (!tx_full_s || tx_pop_s);
    assign rx_pop_s  = rd_rx_s && !rx_empty_s;
    assign rx_push_s = rx_good_s && (!rx_full_s || rx_pop_s);
    assign set_ovr_s = rx_good_s && rx_full_s && !rx_pop_s;

    assign tx_busy_s = (tx_state_q != S_IDLE);
    assign status_s  = {tx_busy_s, perr_q, ferr_q, ovr_q, rx_full_s, !rx_empty_s, tx_empty_s, tx_full_s};

    always_ff @(posedge clk_i) begin
        if (tx_push_s) tx_mem[tx_wp_q[AW-1:0]] <= wr_data_i[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (rx_push_s) rx_mem[rx_wp_q[AW-1:0]] <= rx_sh_q;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_baud_d  = tx_baud_q;
        tx_cfg_d   = tx_cfg_q;
        tx_par_d   = tx_par_q;
        tx_stop_d  = tx_stop_q;
        tx_tick_s  = (tx_cnt_q == 16'd0);
        tx_cnt_d   = tx_tick_s ? (tx_baud_q - 16'd1) : (tx_cnt_q - 16'd1);
        tx_line_d  = 1'b1;
        tx_done_s  = 1'b0;
        tx_pop_s   = 1'b0;
        case (tx_state_q)
            S_IDLE:  tx_line_d = 1'b1;
            S_START: begin
                tx_line_d = 1'b0;
                if (tx_tick_s) begin
                    tx_state_d = S_DATA;
                    tx_bit_d   = 3'd0;
                end else begin
                    tx_state_d = S_START;
                end
            end
            S_DATA: begin
                tx_line_d = tx_sh_q[0];
                if (tx_tick_s) begin
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = tx_cfg_q[0] ? S_PARITY : S_STOP;
                    else                  tx_state_d = S_DATA;
                end else begin
                    tx_state_d = S_DATA;
                end
            end
            S_PARITY: begin
                tx_line_d = tx_par_q;
                if (tx_tick_s) tx_state_d = S_STOP;
                else           tx_state_d = S_PARITY;
            end
            S_STOP: begin
                tx_line_d = 1'b1;
                if (tx_tick_s && tx_cfg_q[2] && !tx_stop_q) begin
                    tx_stop_d = 1'b1;
                end else if (tx_tick_s) begin
                    tx_done_s  = 1'b1;
                    tx_state_d = S_IDLE;
                end else begin
                    tx_state_d = S_STOP;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        // Chaining straight from the last stop bit keeps back-to-back frames gap-free.
        if ((tx_state_q == S_IDLE || tx_done_s) && ctrl_q[0] && !tx_empty_s) begin
            tx_pop_s   = 1'b1;
            tx_state_d = S_START;
            tx_sh_d    = tx_head_s;
            tx_par_d   = (^tx_head_s) ^ ctrl_q[3];
            tx_cfg_d   = ctrl_q[4:2];
            tx_baud_d  = baud_q;
            tx_cnt_d   = baud_q - 16'd1;
            tx_stop_d  = 1'b0;
        end else begin
            tx_pop_s = 1'b0;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_baud_d  = rx_baud_q;
        rx_cfg_d   = rx_cfg_q;
        rx_pbad_d  = rx_pbad_q;
        rx_tick_s  = (rx_cnt_q == 16'd0);
        rx_cnt_d   = rx_tick_s ? (rx_baud_q - 16'd1) : (rx_cnt_q - 16'd1);
        rx_good_s  = 1'b0;
        set_ferr_s = 1'b0;
        set_perr_s = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (ctrl_q[1] && rx_s3_q && !rx_s2_q) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = (baud_q >> 1) - 16'd1;
                    rx_baud_d  = baud_q;
                    rx_cfg_d   = ctrl_q[3:2];
                    rx_pbad_d  = 1'b0;
                end else begin
                    rx_state_d = S_IDLE;
                end
            end
            S_START: begin
                if (rx_tick_s && rx_s2_q) begin
                    rx_state_d = S_IDLE;
                end else if (rx_tick_s) begin
                    rx_state_d = S_DATA;
                    rx_bit_d   = 3'd0;
                end else begin
                    rx_state_d = S_START;
                end
            end
            S_DATA: begin
                if (rx_tick_s) begin
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = rx_cfg_q[0] ? S_PARITY : S_STOP;
                    else                  rx_state_d = S_DATA;
                end else begin
                    rx_state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (rx_tick_s) begin
                    rx_state_d = S_STOP;
                    if (rx_s2_q != ((^rx_sh_q) ^ rx_cfg_q[1])) begin
                        rx_pbad_d  = 1'b1;
                        set_perr_s = 1'b1;
                    end else begin
                        rx_pbad_d  = 1'b0;
                    end
                end else begin
                    rx_state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (rx_tick_s) begin
                    rx_state_d = S_IDLE;
                    set_ferr_s = !rx_s2_q;
                    rx_good_s  = rx_s2_q && !rx_pbad_q;
                end else begin
                    rx_state_d = S_STOP;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (rd_addr_i[7:0])
            8'h00:   rd_mux_s = {25'd0, ctrl_q};
            8'h04:   rd_mux_s = {24'd0, status_s};
            8'h08:   rd_mux_s = {16'd0, baud_q};
            8'h10:   rd_mux_s = rx_empty_s ? 32'd0 : {24'd0, rx_head_s};
            default: rd_mux_s = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q <= 7'd0;  baud_q <= 16'(BAUD_RST);
            ovr_q  <= 1'b0;  ferr_q <= 1'b0;  perr_q <= 1'b0;  irq_q <= 1'b0;
            rd_data_q <= 32'd0;
            tx_wp_q <= '0;  tx_rp_q <= '0;  rx_wp_q <= '0;  rx_rp_q <= '0;
            tx_state_q <= S_IDLE;  tx_cnt_q <= 16'd0;  tx_baud_q <= 16'd0;
            tx_bit_q <= 3'd0;  tx_cfg_q <= 3'd0;  tx_sh_q <= 8'd0;
            tx_par_q <= 1'b0;  tx_stop_q <= 1'b0;  tx_line_q <= 1'b1;
            rx_state_q <= S_IDLE;  rx_cnt_q <= 16'd0;  rx_baud_q <= 16'd0;
            rx_bit_q <= 3'd0;  rx_cfg_q <= 2'd0;  rx_sh_q <= 8'd0;  rx_pbad_q <= 1'b0;
            rx_s1_q <= 1'b1;  rx_s2_q <= 1'b1;  rx_s3_q <= 1'b1;
        end else begin
            if (wr_ctrl_s) ctrl_q <= wr_data_i[6:0];
            if (wr_baud_s) baud_q <= (wr_data_i[15:0] < 16'd16) ? 16'd16 : wr_data_i[15:0];
            // Hardware set beats a same-cycle write-one-to-clear.
            ovr_q  <= set_ovr_s  || (ovr_q  && !(wr_stat_s && wr_data_i[4]));
            ferr_q <= set_ferr_s || (ferr_q && !(wr_stat_s && wr_data_i[5]));
            perr_q <= set_perr_s || (perr_q && !(wr_stat_s && wr_data_i[6]));
            irq_q  <= (ctrl_q[5] && !rx_empty_s) || (ctrl_q[6] && tx_empty_s && !tx_busy_s)
                      || ovr_q || ferr_q || perr_q;
            if (rd_en_i) rd_data_q <= rd_mux_s;
            if (tx_push_s) tx_wp_q <= tx_wp_q + PTR_ONE;
            if (tx_pop_s)  tx_rp_q <= tx_rp_q + PTR_ONE;
            if (rx_push_s) rx_wp_q <= rx_wp_q + PTR_ONE;
            if (rx_pop_s)  rx_rp_q <= rx_rp_q + PTR_ONE;
            tx_state_q <= tx_state_d;  tx_cnt_q <= tx_cnt_d;  tx_baud_q <= tx_baud_d;
            tx_bit_q <= tx_bit_d;  tx_cfg_q <= tx_cfg_d;  tx_sh_q <= tx_sh_d;
            tx_par_q <= tx_par_d;  tx_stop_q <= tx_stop_d;  tx_line_q <= tx_line_d;
            rx_state_q <= rx_state_d;  rx_cnt_q <= rx_cnt_d;  rx_baud_q <= rx_baud_d;
            rx_bit_q <= rx_bit_d;  rx_cfg_q <= rx_cfg_d;  rx_sh_q <= rx_sh_d;  rx_pbad_q <= rx_pbad_d;
            rx_s1_q <= uart_rx_i;  rx_s2_q <= rx_s1_q;  rx_s3_q <= rx_s2_q;
        end
    end

    assign uart_tx_o = tx_line_q;
    assign rd_data_o = rd_data_q;
    assign irq_o     = irq_q;
endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: register vector table plus serial-line sequences.
module tb_uart_fifo;
    logic        clk = 1'b0;
    logic        rst, rx_drv, loop_en, rx_line, tx, irq;
    logic        wr_en, rd_en;
    logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;

    typedef struct {
        logic        is_wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [18];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign rx_line = loop_en ? tx : rx_drv;

    uart_fifo #(.FIFO_DEPTH(16), .BAUD_RST(434)) dut (
        .clk_i(clk), .rst_i(rst), .uart_rx_i(rx_line), .uart_tx_o(tx),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .irq_o(irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = {24'd0, a}; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic reg_rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        rd_en = 1'b1; rd_addr = {24'd0, a};
        @(negedge clk);
        rd_en = 1'b0;
        d = rd_data;
    endtask

    // Drive one frame at 16 cycles/bit onto the RX line, followed by one idle bit.
    task automatic send_frame(input logic [7:0] b, input bit par_en, input bit par_odd,
                              input bit flip_par, input bit bad_stop);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (16) @(negedge clk);
        end
        if (par_en) begin
            rx_drv = (^b) ^ par_odd ^ flip_par;
            repeat (16) @(negedge clk);
        end
        rx_drv = ~bad_stop;
        repeat (16) @(negedge clk);
        rx_drv = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    // Wait (bounded) for a start bit on uart_tx_o and sample the frame mid-bit.
    task automatic tx_capture(input bit par_en, output logic [7:0] b, output logic p,
                              output int t0, output bit ok);
        int n;
        ok = 1'b0; b = 8'd0; p = 1'b0; t0 = 0; n = 0;
        @(negedge clk);
        while (tx !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) return;
        t0 = cyc; ok = 1'b1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (16) @(negedge clk);
            b[i] = tx;
        end
        if (par_en) begin
            repeat (16) @(negedge clk);
            p = tx;
        end
        repeat (16) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        logic        p;
        int          t0, t1;
        bit          ok;

        tbl[0]  = '{1'b0, 8'h00, 32'h0,         32'h0};
        tbl[1]  = '{1'b0, 8'h04, 32'h0,         32'h2};
        tbl[2]  = '{1'b0, 8'h08, 32'h0,         32'd434};
        tbl[3]  = '{1'b0, 8'h10, 32'h0,         32'h0};
        tbl[4]  = '{1'b0, 8'h14, 32'h0,         32'h0};
        tbl[5]  = '{1'b1, 8'h00, 32'h0000_00FF, 32'h0};
        tbl[6]  = '{1'b0, 8'h00, 32'h0,         32'h7F};
        tbl[7]  = '{1'b1, 8'h08, 32'd5,         32'h0};
        tbl[8]  = '{1'b0, 8'h08, 32'h0,         32'd16};
        tbl[9]  = '{1'b1, 8'h08, 32'hABCD_1234, 32'h0};
        tbl[10] = '{1'b0, 8'h08, 32'h0,         32'h1234};
        tbl[11] = '{1'b1, 8'h04, 32'hFFFF_FFFF, 32'h0};
        tbl[12] = '{1'b0, 8'h04, 32'h0,         32'h2};
        tbl[13] = '{1'b1, 8'h20, 32'hFF,        32'h0};
        tbl[14] = '{1'b0, 8'h20, 32'h0,         32'h0};
        tbl[15] = '{1'b1, 8'h00, 32'h0,         32'h0};
        tbl[16] = '{1'b1, 8'h08, 32'd16,        32'h0};
        tbl[17] = '{1'b0, 8'h08, 32'h0,         32'd16};

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_addr = 32'd0; wr_data = 32'd0;
        rd_addr = 32'd0; rx_drv = 1'b1; loop_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_rd_data", rd_data, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].is_wr) begin
                reg_wr(tbl[i].addr, tbl[i].data);
            end else begin
                reg_rd(tbl[i].addr, d);
                check($sformatf("vec%0d", i), d, tbl[i].exp);
            end
        end

        // Loopback 0xA5 with tx_en|rx_en at BAUD=16.
        loop_en = 1'b1;
        reg_wr(8'h00, 32'h03);
        reg_wr(8'h0C, 32'hA5);
        @(negedge clk);
        check("tx_high_1cyc", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check("tx_fall_2cyc", {31'd0, tx}, 32'd0);
        repeat (170) @(negedge clk);
        reg_rd(8'h10, d);
        check("loop_rxdata", d, 32'hA5);
        repeat (4) @(negedge clk);
        check("rd_data_hold", rd_data, 32'hA5);
        reg_rd(8'h04, d);
        check("loop_status", d, 32'h02);
        reg_rd(8'h10, d);
        check("rx_empty_read", d, 32'h0);
        loop_en = 1'b0;

        // TX odd parity, two queued frames back to back.
        reg_wr(8'h00, 32'h0C);
        reg_wr(8'h0C, 32'h01);
        reg_wr(8'h0C, 32'h01);
        reg_wr(8'h00, 32'h0D);
        tx_capture(1'b1, b, p, t0, ok);
        check("par_frame_seen", {31'd0, ok}, 32'd1);
        check("par_byte", {24'd0, b}, 32'h01);
        check("par_bit", {31'd0, p}, 32'd0);
        tx_capture(1'b1, b, p, t1, ok);
        check("par_frame_len", t1 - t0, 32'd176);

        // RX parity error, then a good parity frame.
        reg_wr(8'h00, 32'h0E);
        send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
        reg_rd(8'h04, d);
        check("perr_status", d, 32'h42);
        check("perr_irq", {31'd0, irq}, 32'd1);
        reg_wr(8'h04, 32'h40);
        reg_rd(8'h04, d);
        check("perr_clear", d, 32'h02);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
        reg_rd(8'h10, d);
        check("par_good_rx", d, 32'h5A);

        // Fill TX FIFO past depth with TX disabled, then drain.
        reg_wr(8'h00, 32'h00);
        for (int i = 0; i < 17; i++) reg_wr(8'h0C, 32'h30 + i);
        reg_rd(8'h04, d);
        check("tx_full_status", d, 32'h01);
        reg_wr(8'h00, 32'h01);
        for (int i = 0; i < 16; i++) begin
            tx_capture(1'b0, b, p, t0, ok);
            check($sformatf("tx_order%0d", i), {23'd0, ok, b}, {23'd0, 1'b1, 8'h30 + 8'(i)});
        end
        tx_capture(1'b0, b, p, t0, ok);
        check("tx_no_17th", {31'd0, ok}, 32'd0);
        reg_rd(8'h04, d);
        check("tx_drained", d, 32'h02);

        // Overfill RX FIFO.
        reg_wr(8'h00, 32'h02);
        for (int i = 0; i < 17; i++) send_frame(8'h40 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        reg_rd(8'h04, d);
        check("rx_full_status", d, 32'h1E);
        check("ovr_irq", {31'd0, irq}, 32'd1);
        reg_wr(8'h04, 32'h10);
        reg_rd(8'h04, d);
        check("ovr_clear", d, 32'h0E);
        for (int i = 0; i < 16; i++) begin
            reg_rd(8'h10, d);
            check($sformatf("rx_order%0d", i), d, 32'h40 + i);
        end
        reg_rd(8'h04, d);
        check("rx_drained", d, 32'h02);
        check("irq_quiet", {31'd0, irq}, 32'd0);

        // Short low glitch, then a frame with a bad stop bit.
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (5) @(negedge clk);
        rx_drv = 1'b1;
        repeat (50) @(negedge clk);
        reg_rd(8'h04, d);
        check("glitch_ignored", d, 32'h02);
        send_frame(8'h33, 1'b0, 1'b0, 1'b0, 1'b1);
        reg_rd(8'h04, d);
        check("frame_err", d, 32'h22);
        reg_rd(8'h10, d);
        check("frame_err_nopush", d, 32'h0);

        // Reset in the middle of a TX frame.
        reg_wr(8'h00, 32'h01);
        reg_wr(8'h0C, 32'h00);
        repeat (40) @(negedge clk);
        check("mid_frame_low", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        #1;
        check("rst_tx_async", {31'd0, tx}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        reg_rd(8'h00, d);
        check("rst_ctrl", d, 32'h0);
        reg_rd(8'h08, d);
        check("rst_baud", d, 32'd434);
        reg_rd(8'h04, d);
        check("rst_status", d, 32'h02);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
